// File: rtl/cell_pos_writer.sv
// cell_pos_writer: streams particle positions into a cell RAM at addresses 1..N, then commits N to address 0.
// Define CELL_POS_WRITER_CLEAR_EN to zero stale words above N before the commit.
module cell_pos_writer #(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_wren,
  output logic                  ram_rden,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [ADDR_WIDTH-1:0] count
);
  localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  wren;
  } ram_req_t;

`ifdef CELL_POS_WRITER_CLEAR_EN
  typedef enum logic [1:0] {IDLE, FILL, CLEAR, COMMIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;
`endif

  state_t                state;
  ram_req_t              ram_q;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  take;
  logic                  room;
  logic [ADDR_WIDTH-1:0] cnt_nxt;

  // in_ready is high only in FILL, so take implies FILL
  assign take    = in_valid && in_ready;
  assign room    = (count < MAX_CNT);
  assign cnt_nxt = room ? count + ONE : count;

  assign ram_address = ram_q.addr;
  assign ram_data    = ram_q.data;
  assign ram_wren    = ram_q.wren;
  assign ram_rden    = 1'b0;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ram_q    <= '0;
      ptr      <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      count    <= '0;
    end else begin
      ram_q.wren <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state    <= FILL;
          count    <= '0;
          overflow <= 1'b0;
          ptr      <= ONE;
          in_ready <= 1'b1;
          busy     <= 1'b1;
        end
        FILL: if (take) begin
          if (room) begin
            ram_q <= '{addr: ptr, data: in_data, wren: 1'b1};
            ptr   <= ptr + ONE;
            count <= cnt_nxt;
          end else begin
            overflow <= 1'b1;
          end
          if (in_last) begin
            in_ready <= 1'b0;
`ifdef CELL_POS_WRITER_CLEAR_EN
            state <= (cnt_nxt < MAX_CNT) ? CLEAR : COMMIT;
`else
            state <= COMMIT;
`endif
          end
        end
`ifdef CELL_POS_WRITER_CLEAR_EN
        CLEAR: begin
          // ptr already sits at count+1 when CLEAR is entered
          ram_q <= '{addr: ptr, data: '0, wren: 1'b1};
          if (ptr == MAX_CNT) state <= COMMIT;
          else                ptr   <= ptr + ONE;
        end
`endif
        COMMIT: begin
          ram_q <= '{addr: '0, data: {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, count}, wren: 1'b1};
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
